bit_to_word_fifo: RTL
=====================

Name: bit_to_word_fifo

Overview:
- Reader-side counterpart to the team's bit-serial FIFO/delay-line blocks.
- Consumes a 1-bit stream qualified by i_ce and packs it into DW-bit words, LSB first.
- Buffers the packed words in a small synchronous FIFO.
- Presents the words on a first-word-fall-through valid/ready read port for the word-wide logic downstream.

Parameters:
- DW, 8, word width in bits (>=2).
- LGDEPTH, 2, log2 of word FIFO depth (depth = 4 words by default).

Ports:
- i_clk  input  1  system clock; all logic on posedge.
- i_reset  input  1  synchronous, active-high reset.
- i_ce  input  1  serial bit strobe; i_data sampled when high.
- i_data  input  1  serial data bit.
- o_valid  output  1  word FIFO non-empty.
- o_data  output  DW  word at FIFO head (fall-through).
- i_ready  input  1  downstream accepts head word when o_valid&&i_ready.
- o_fill  output  LGDEPTH+1  words currently stored, 0..2^LGDEPTH.
- o_overflow  output  1  sticky: a completed word was dropped.

Behaviour:
Clock and reset
- One clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset clears: bit counter=0, shift register=0, read/write pointers=0, o_fill=0, o_valid=0, o_overflow=0, o_data=0.
- Reset takes priority over all other inputs in the same cycle.
- A partially assembled word at reset is discarded.

Packing
- Bit counter runs 0..DW-1.
- On i_ce, i_data goes into bit position [count].
- The first bit after reset or after a word completes is word bit 0.
- When i_ce arrives with count==DW-1, the word is complete:
  - the full word (including this bit) is pushed into the FIFO;
  - count wraps to 0.
- No i_ce: counter and shift register hold.

Push/pop
- Push occurs in the completing cycle. The word is visible at o_data with o_valid=1 on the next edge, giving a latency of 1 cycle from the last bit's i_ce edge.
- Pop when o_valid&&i_ready: rd_ptr advances; o_data shows the next entry, or stays stale with o_valid=0.
- i_ready while o_valid=0 is ignored.
- Push with fill==2^LGDEPTH and no pop that cycle:
  - word dropped, o_overflow<=1, fill unchanged;
  - the bit counter still wraps, so packing alignment is preserved.
- Push and pop in the same cycle when full: the push is accepted and fill stays 2^LGDEPTH.
- Push and pop in the same cycle at any fill: fill unchanged; the pointers advance.
- Push only: fill+1. Pop only: fill-1.

Pointers and flags
- Pointers are LGDEPTH bits wide and wrap modulo depth.
- o_valid = (fill!=0), registered consistently with fill.
- o_data = mem[rd_ptr], read combinationally (fall-through).
- o_overflow stays set until i_reset.

Test Plan:
- Reset, then i_ce with bits 1,0,1,1,0,0,1,0 (DW=8) -> one cycle after the 8th bit: o_valid=1, o_data=8'h4D, o_fill=1.
- Same stream, i_ce toggled every other cycle with i_ready=1 -> single word 8'h4D seen once, then o_valid=0, o_fill=0.
- Five words 8'h01..8'h05 with i_ready=0 -> o_fill=4, o_overflow=1. Pop 4 -> reads 8'h01,02,03,04; o_valid=0; o_overflow still 1.
- Fill to 4 words, then complete a 5th word (8'hAA) while i_ready=1 on the same cycle -> o_overflow stays 0, o_fill=4, last word read is 8'hAA.
- Assert i_reset after 3 bits of a word, then send 8 bits of 8'hF0 -> o_data=8'hF0 (no stale bits), o_fill=1.
- Random i_ce/i_data/i_ready over 10k cycles vs. a reference model -> data order matches, fill never exceeds 4, overflow matches the model.

Source files
------------

// File: rtl/bit_to_word_fifo.sv
// Packs an i_ce-qualified serial bit stream into DW-bit words (LSB first) and
// buffers them in a small first-word-fall-through FIFO with a sticky overflow flag.
module bit_to_word_fifo #(
  parameter int DW      = 8,
  parameter int LGDEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ce,
  input  logic               i_data,
  output logic               o_valid,
  output logic [DW-1:0]      o_data,
  input  logic               i_ready,
  output logic [LGDEPTH:0]   o_fill,
  output logic               o_overflow
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam int CW    = $clog2(DW);

  logic [CW-1:0]      bit_cnt;
  logic [DW-1:0]      sreg;
  logic [DW-1:0]      word_nxt;
  logic [DW-1:0]      mem [DEPTH];
  logic [LGDEPTH-1:0] rd_ptr;
  logic [LGDEPTH-1:0] wr_ptr;
  logic [LGDEPTH:0]   fill_nxt;
  logic               word_done;
  logic               full;
  logic               pop;
  logic               push_ok;

  // Current word with the incoming bit merged in, so the completing bit lands in the pushed word.
  always_comb begin
    word_nxt          = sreg;
    word_nxt[bit_cnt] = i_data;
  end

  assign word_done = i_ce && (bit_cnt == CW'(DW - 1));
  assign full      = (o_fill == (LGDEPTH + 1)'(DEPTH));
  assign pop       = o_valid && i_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
  assign push_ok   = word_done && (!full || pop);

  always_comb begin
    fill_nxt = o_fill;
    if (push_ok && !pop)
      fill_nxt = o_fill + (LGDEPTH + 1)'(1);
    else if (!push_ok && pop)
      fill_nxt = o_fill - (LGDEPTH + 1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bit_cnt    <= '0;
      sreg       <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      o_fill     <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (i_ce) begin
        sreg    <= word_nxt;
        bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
      end
      if (push_ok) begin
        mem[wr_ptr] <= word_nxt;
        wr_ptr      <= wr_ptr + LGDEPTH'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + LGDEPTH'(1);
      if (word_done && full && !pop)
        o_overflow <= 1'b1;
      o_fill  <= fill_nxt;
      o_valid <= (fill_nxt != '0);
    end
  end

  assign o_data = mem[rd_ptr];

endmodule
